// File: rtl/button_conditioner.sv
// button_conditioner: per-button synchroniser, debouncer and rising-edge pulse generator.
// Ports: clk, async_nreset (async assert, active-low), btn_raw[NUM_BTN] raw levels,
//        btn_level[NUM_BTN] debounced level, btn_re[NUM_BTN] one-cycle press strobe.
// Optional: define BUTTON_CONDITIONER_AUTO_REPEAT_EN for held-button auto-repeat strobes.
module button_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic               clk,
    input  logic               async_nreset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_re
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // bit 1 is the accepted level, bit 0 flags a running debounce count
    typedef enum logic [1:0] {
        LOW       = 2'b00,
        RISE_WAIT = 2'b01,
        HIGH      = 2'b10,
        FALL_WAIT = 2'b11
    } state_t;
    logic [NUM_BTN-1:0] s1, s2;
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        state_t         state, state_nx;
        logic [CW-1:0]  cnt, cnt_nx;
        logic           stable, stable_nx, re_q, rep_fire;
        assign stable = state[1];
        always_comb begin
            cnt_nx    = '0;
            stable_nx = stable;
            if (s2[g] != stable) begin
                if (cnt == CNT_LAST)
                    stable_nx = s2[g];
                else
                    cnt_nx = cnt + 1'b1;
            end
            state_nx = state_t'({stable_nx, cnt_nx != '0});
        end
        always_ff @(posedge clk or negedge async_nreset) begin
            if (!async_nreset) begin
                state <= LOW;
                cnt   <= '0;
                re_q  <= 1'b0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                re_q  <= (!stable && stable_nx) || rep_fire;
            end
        end
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        localparam int RW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1;
        logic [RW-1:0] rcnt;
        logic          rep_phase, rep_last;
        // rep_phase selects the initial delay versus the steady repeat period
        assign rep_last = rcnt == (rep_phase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
        // only a settled HIGH with no pending mismatch may repeat
        assign rep_fire = state == HIGH && s2[g] && rep_last;
        always_ff @(posedge clk or negedge async_nreset) begin
            if (!async_nreset) begin
                rcnt      <= '0;
                rep_phase <= 1'b0;
            end else if (!stable && stable_nx) begin
                rcnt      <= '0;
                rep_phase <= 1'b0;
            end else if (stable) begin
                // a due repeat suppressed by FALL_WAIT is held so an aborted release resumes the phase
                rcnt      <= rep_last ? (rep_fire ? '0 : rcnt) : rcnt + 1'b1;
                rep_phase <= rep_phase | rep_fire;
            end
        end
`else
        assign rep_fire = 1'b0;
`endif
        assign btn_level[g] = stable;
        assign btn_re[g]    = re_q;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed table-driven check of button_conditioner with default parameters.
module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       async_nreset = 1'b1;
    logic [2:0] btn_raw = 3'b000;
    logic [2:0] btn_level, btn_re;
    int checks = 0;
    int errors = 0;

    button_conditioner dut (
        .clk(clk),
        .async_nreset(async_nreset),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_re(btn_re)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] raw;
        logic [2:0] level;
        logic [2:0] re;
        int         n;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] raw, input logic [2:0] level, input logic [2:0] re, input int n);
        vec_t v;
        v.raw = raw;
        v.level = level;
        v.re = re;
        v.n = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [2:0] raw);
        btn_raw = raw;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        int found;
        // reset: asserted between clock edges, outputs must clear without a clock edge
        #2 async_nreset = 1'b0;
        #1;
        chk("reset_level", 32'(btn_level), 32'h0);
        chk("reset_re", 32'(btn_re), 32'h0);
        #4 async_nreset = 1'b1;
        @(negedge clk);
        chk("post_reset_level", 32'(btn_level), 32'h0);
        chk("post_reset_re", 32'(btn_re), 32'h0);

        // clean press/release on bit 0
        tbl.push_back(mk(3'b001, 3'b000, 3'b000, 5));
        tbl.push_back(mk(3'b001, 3'b001, 3'b001, 1));
        tbl.push_back(mk(3'b001, 3'b001, 3'b000, 14));
        tbl.push_back(mk(3'b000, 3'b001, 3'b000, 5));
        tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3));
        // 3-cycle glitch on bit 2 rejected
        tbl.push_back(mk(3'b100, 3'b000, 3'b000, 3));
        tbl.push_back(mk(3'b000, 3'b000, 3'b000, 8));
        // bounce on bit 1 then hold
        tbl.push_back(mk(3'b010, 3'b000, 3'b000, 1));
        tbl.push_back(mk(3'b000, 3'b000, 3'b000, 1));
        tbl.push_back(mk(3'b010, 3'b000, 3'b000, 1));
        tbl.push_back(mk(3'b000, 3'b000, 3'b000, 1));
        tbl.push_back(mk(3'b010, 3'b000, 3'b000, 5));
        tbl.push_back(mk(3'b010, 3'b010, 3'b010, 1));
        tbl.push_back(mk(3'b010, 3'b010, 3'b000, 4));
        tbl.push_back(mk(3'b000, 3'b010, 3'b000, 5));
        tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3));
        // simultaneous press on all channels
        tbl.push_back(mk(3'b111, 3'b000, 3'b000, 5));
        tbl.push_back(mk(3'b111, 3'b111, 3'b111, 1));
        tbl.push_back(mk(3'b111, 3'b111, 3'b000, 3));
        tbl.push_back(mk(3'b000, 3'b111, 3'b000, 5));
        tbl.push_back(mk(3'b000, 3'b000, 3'b000, 3));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                step(tbl[i].raw);
                chk($sformatf("vec%0d.%0d_level", i, k), 32'(btn_level), 32'(tbl[i].level));
                chk($sformatf("vec%0d.%0d_re", i, k), 32'(btn_re), 32'(tbl[i].re));
            end
        end

        // mid-cycle reset while held, then a full debounce after release
        for (int k = 0; k < 6; k++) step(3'b001);
        chk("held_level", 32'(btn_level), 32'h1);
        @(posedge clk);
        #3 async_nreset = 1'b0;
        #1;
        chk("midcycle_reset_level", 32'(btn_level), 32'h0);
        chk("midcycle_reset_re", 32'(btn_re), 32'h0);
        @(negedge clk);
        async_nreset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rerelease%0d_level", k), 32'(btn_level), (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("rerelease%0d_re", k), 32'(btn_re), (k == 5) ? 32'h1 : 32'h0);
        end
        for (int k = 0; k < 8; k++) step(3'b000);
        chk("rerelease_drop", 32'(btn_level), 32'h0);

        // 100 presses spaced 12 clocks
        pulses = 0;
        for (int p = 0; p < 100; p++) begin
            for (int k = 0; k < 12; k++) begin
                step(k < 6 ? 3'b001 : 3'b000);
                if (btn_re[0]) pulses++;
                if (btn_re[2:1] != 2'b00) chk("burst_other_re", 32'(btn_re), 32'h0);
            end
        end
        for (int k = 0; k < 10; k++) begin
            step(3'b000);
            if (btn_re[0]) pulses++;
        end
        chk("burst_pulse_count", 32'(pulses), 32'd100);

        // long hold: auto-repeat pattern when enabled, otherwise a single pulse
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            step(3'b001);
            if (btn_re[0]) found = 1;
        end
        chk("hold_first_pulse", 32'(found), 32'h1);
        for (int k = 1; k <= 50; k++) begin
            step(3'b001);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
            chk($sformatf("hold+%0d_re", k), 32'(btn_re), (k >= 16 && (k - 16) % 8 == 0) ? 32'h1 : 32'h0);
`else
            chk($sformatf("hold+%0d_re", k), 32'(btn_re), 32'h0);
`endif
        end
        for (int k = 0; k < 20; k++) begin
            step(3'b000);
            chk($sformatf("hold_release%0d_re", k), 32'(btn_re), 32'h0);
        end
        chk("hold_release_level", 32'(btn_level), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
